// File: rtl/dh_frame_sequencer.sv
// Front-end sequencer for the DH forward-kinematics core: parameter table, theta FIFO, result re-timer.
// Define DH_SEQ_OUT_HOLD_EN to keep OUT_X/Y/Z at the last result while OUT_VALID is low.
module dh_frame_sequencer #(
    parameter int unsigned NJ    = 4,
    parameter int unsigned ANG_W = 6,
    parameter int unsigned LEN_W = 3,
    parameter int unsigned OUT_W = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IN_VALID_1,
    input  logic [ANG_W-1:0]      ALPHA_I,
    input  logic [LEN_W-1:0]      A_I,
    input  logic [LEN_W-1:0]      D_I,
    input  logic                  IN_VALID_2,
    input  logic [NJ*ANG_W-1:0]   THETA_VEC,
    output logic                  core_valid,
    input  logic                  core_ready,
    output logic [NJ*ANG_W-1:0]   core_theta,
    output logic [NJ*ANG_W-1:0]   core_alpha,
    output logic [NJ*LEN_W-1:0]   core_a,
    output logic [NJ*LEN_W-1:0]   core_d,
    input  logic                  res_valid,
    input  logic [OUT_W-1:0]      res_x,
    input  logic [OUT_W-1:0]      res_y,
    input  logic [OUT_W-1:0]      res_z,
    output logic                  OUT_VALID,
    output logic [OUT_W-1:0]      OUT_X,
    output logic [OUT_W-1:0]      OUT_Y,
    output logic [OUT_W-1:0]      OUT_Z,
    output logic                  busy,
    output logic                  err_short,
    output logic                  err_ovf
);

    localparam int unsigned IDX_W  = $clog2(NJ);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned PEND_W = $clog2(2 * DEPTH) + 1;

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NJ - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               v2_prev_q;
    logic               pushed_q;
    logic               err_short_q;
    logic               err_ovf_q;

    logic [ANG_W-1:0]   alpha_tab_q [NJ];
    logic [LEN_W-1:0]   a_tab_q     [NJ];
    logic [LEN_W-1:0]   d_tab_q     [NJ];

    logic [NJ*ANG_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]      wr_ptr_q;
    logic [PTR_W:0]      rd_ptr_q;
    logic [PEND_W-1:0]   pending_q;
    logic [PEND_W-1:0]   pending_d;

    logic               out_valid_q;
    logic [OUT_W-1:0]   out_x_q;
    logic [OUT_W-1:0]   out_y_q;
    logic [OUT_W-1:0]   out_z_q;

    logic fifo_empty;
    logic fifo_full;
    logic push_req;
    logic push;
    logic drop;
    logic pop;
    logic res_ok;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign push_req = (state_q == StRun) && IN_VALID_2;
    assign push     = push_req && !fifo_full;
    assign drop     = push_req && fifo_full;
    assign pop      = !fifo_empty && core_ready;
    assign res_ok   = res_valid && (pending_q != '0);

    always_comb begin
        pending_d = pending_q;
        if (push && !res_ok) begin
            if (pending_q != PEND_MAX) begin
                pending_d = pending_q + 1'b1;
            end
        end else if (!push && res_ok) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            pushed_q    <= 1'b0;
            err_short_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            for (int j = 0; j < int'(NJ); j++) begin
                alpha_tab_q[j] <= '0;
                a_tab_q[j]     <= '0;
                d_tab_q[j]     <= '0;
            end
        end else begin
            err_short_q <= 1'b0;
            err_ovf_q   <= drop;
            unique case (state_q)
                StIdle: begin
                    if (IN_VALID_1) begin
                        // A new load starts from a blank table so a short burst leaves zeros behind.
                        for (int j = 1; j < int'(NJ); j++) begin
                            alpha_tab_q[j] <= '0;
                            a_tab_q[j]     <= '0;
                            d_tab_q[j]     <= '0;
                        end
                        alpha_tab_q[0] <= ALPHA_I;
                        a_tab_q[0]     <= A_I;
                        d_tab_q[0]     <= D_I;
                        idx_q          <= IDX_W'(1);
                        state_q        <= StLoad;
                    end
                end
                StLoad: begin
                    if (IN_VALID_1) begin
                        alpha_tab_q[idx_q] <= ALPHA_I;
                        a_tab_q[idx_q]     <= A_I;
                        d_tab_q[idx_q]     <= D_I;
                        if (idx_q == IDX_LAST) begin
                            idx_q    <= '0;
                            pushed_q <= 1'b0;
                            state_q  <= StRun;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        err_short_q <= 1'b1;
                        idx_q       <= '0;
                        state_q     <= StIdle;
                    end
                end
                StRun: begin
                    if (push) begin
                        pushed_q <= 1'b1;
                    end
                    if (v2_prev_q && !IN_VALID_2 && pushed_q) begin
                        pushed_q <= 1'b0;
                        state_q  <= StDrain;
                    end
                end
                StDrain: begin
                    if (pending_q == '0) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_prev_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            v2_prev_q <= IN_VALID_2;
            pending_q <= pending_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: it is only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= THETA_VEC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
        end else begin
            out_valid_q <= res_ok;
            if (res_ok) begin
                out_x_q <= res_x;
                out_y_q <= res_y;
                out_z_q <= res_z;
            end else begin
`ifdef DH_SEQ_OUT_HOLD_EN
                out_x_q <= out_x_q;
                out_y_q <= out_y_q;
                out_z_q <= out_z_q;
`else
                out_x_q <= '0;
                out_y_q <= '0;
                out_z_q <= '0;
`endif
            end
        end
    end

    for (genvar j = 0; j < int'(NJ); j++) begin : g_pack
        assign core_alpha[j*ANG_W +: ANG_W] = alpha_tab_q[j];
        assign core_a[j*LEN_W +: LEN_W]     = a_tab_q[j];
        assign core_d[j*LEN_W +: LEN_W]     = d_tab_q[j];
    end

    assign core_valid = !fifo_empty;
    assign core_theta = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign OUT_VALID  = out_valid_q;
    assign OUT_X      = out_x_q;
    assign OUT_Y      = out_y_q;
    assign OUT_Z      = out_z_q;
    assign busy       = (state_q != StIdle);
    assign err_short  = err_short_q;
    assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_dh_frame_sequencer.sv
// Directed bench for dh_frame_sequencer; expectations follow DH_SEQ_OUT_HOLD_EN when defined.
module tb_dh_frame_sequencer;

    localparam int NJ    = 4;
    localparam int ANG_W = 6;
    localparam int LEN_W = 3;
    localparam int OUT_W = 9;
    localparam int DEPTH = 4;
`ifdef DH_SEQ_OUT_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid_1;
    logic [ANG_W-1:0]    alpha_i;
    logic [LEN_W-1:0]    a_i;
    logic [LEN_W-1:0]    d_i;
    logic                in_valid_2;
    logic [NJ*ANG_W-1:0] theta_vec;
    logic                core_valid;
    logic                core_ready;
    logic [NJ*ANG_W-1:0] core_theta;
    logic [NJ*ANG_W-1:0] core_alpha;
    logic [NJ*LEN_W-1:0] core_a;
    logic [NJ*LEN_W-1:0] core_d;
    logic                res_valid;
    logic [OUT_W-1:0]    res_x, res_y, res_z;
    logic                out_valid;
    logic [OUT_W-1:0]    out_x, out_y, out_z;
    logic                busy, err_short, err_ovf;

    int n_cmp = 0;
    int n_err = 0;
    logic [OUT_W-1:0] last_x = '0;

    dh_frame_sequencer #(
        .NJ(NJ), .ANG_W(ANG_W), .LEN_W(LEN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .IN_VALID_1(in_valid_1), .ALPHA_I(alpha_i), .A_I(a_i), .D_I(d_i),
        .IN_VALID_2(in_valid_2), .THETA_VEC(theta_vec),
        .core_valid(core_valid), .core_ready(core_ready), .core_theta(core_theta),
        .core_alpha(core_alpha), .core_a(core_a), .core_d(core_d),
        .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .res_z(res_z),
        .OUT_VALID(out_valid), .OUT_X(out_x), .OUT_Y(out_y), .OUT_Z(out_z),
        .busy(busy), .err_short(err_short), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NJ*ANG_W-1:0] tv(input int k);
        return 24'(32'h00A5A5 + k * 32'h041061);
    endfunction

    task automatic drive_load();
        for (int i = 0; i < NJ; i++) begin
            in_valid_1 = 1'b1;
            alpha_i    = 6'(i + 1);
            a_i        = 3'(i + 1);
            d_i        = 3'(7 - i);
            tick();
        end
        in_valid_1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({core_valid, busy, err_short, err_ovf, out_valid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000",
                     {core_valid, busy, err_short, err_ovf, out_valid});
        end
        n_cmp++;
        if ({core_theta, core_alpha, core_a, core_d, out_x, out_y, out_z} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got theta=%h alpha=%h a=%h d=%h x=%0d want all 0",
                     core_theta, core_alpha, core_a, core_d, out_x);
        end
    endtask

    task automatic test_load();
        logic [NJ*ANG_W-1:0] ea;
        logic [NJ*LEN_W-1:0] eaa, ed;
        ea  = {6'd4, 6'd3, 6'd2, 6'd1};
        eaa = {3'd4, 3'd3, 3'd2, 3'd1};
        ed  = {3'd4, 3'd5, 3'd6, 3'd7};
        drive_load();
        n_cmp++;
        if (busy !== 1'b1 || dut.state_q !== 2'd2) begin
            n_err++;
            $display("FAIL load_state: got busy=%b state=%0d want busy=1 state=2", busy, dut.state_q);
        end
        n_cmp++;
        if (core_alpha !== ea || core_a !== eaa || core_d !== ed) begin
            n_err++;
            $display("FAIL load_table: got alpha=%h a=%h d=%h want alpha=%h a=%h d=%h",
                     core_alpha, core_a, core_d, ea, eaa, ed);
        end
        in_valid_1 = 1'b1;
        alpha_i    = 6'd63;
        tick();
        in_valid_1 = 1'b0;
        n_cmp++;
        if (core_alpha !== ea || dut.state_q !== 2'd2) begin
            n_err++;
            $display("FAIL load_ignore_v1_in_run: got alpha=%h state=%0d want alpha=%h state=2",
                     core_alpha, dut.state_q, ea);
        end
    endtask

    task automatic test_streaming();
        core_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid_2 = 1'b1;
            theta_vec  = tv(k);
            tick();
            n_cmp++;
            if (core_valid !== 1'b1 || core_theta !== tv(k)) begin
                n_err++;
                $display("FAIL stream_head%0d: got valid=%b theta=%h want valid=1 theta=%h",
                         k, core_valid, core_theta, tv(k));
            end
        end
        in_valid_2 = 1'b0;
        tick();
        n_cmp++;
        if (core_valid !== 1'b0 || dut.state_q !== 2'd3) begin
            n_err++;
            $display("FAIL stream_drain: got valid=%b state=%0d want valid=0 state=3",
                     core_valid, dut.state_q);
        end
        for (int k = 0; k < 3; k++) begin
            res_valid = 1'b1;
            res_x = 9'(100 + k);
            res_y = 9'(200 + k);
            res_z = 9'(300 + k);
            tick();
            last_x = 9'(100 + k);
            res_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b1 || out_x !== 9'(100 + k) || out_y !== 9'(200 + k)
                || out_z !== 9'(300 + k)) begin
                n_err++;
                $display("FAIL stream_result%0d: got v=%b x=%0d y=%0d z=%0d want v=1 x=%0d y=%0d z=%0d",
                         k, out_valid, out_x, out_y, out_z, 100 + k, 200 + k, 300 + k);
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || out_x !== (HOLD ? last_x : 9'd0)) begin
                n_err++;
                $display("FAIL stream_gap%0d: got v=%b x=%0d want v=0 x=%0d",
                         k, out_valid, out_x, HOLD ? last_x : 9'd0);
            end
            n_cmp++;
            if (busy !== (k < 2)) begin
                n_err++;
                $display("FAIL stream_busy%0d: got %b want %b", k, busy, k < 2);
            end
        end
        core_ready = 1'b0;
    endtask

    task automatic test_short_burst();
        in_valid_2 = 1'b1;
        theta_vec  = tv(9);
        tick();
        in_valid_2 = 1'b0;
        n_cmp++;
        if (core_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL short_idle_v2: got valid=%b busy=%b want 0 0", core_valid, busy);
        end
        for (int i = 0; i < 2; i++) begin
            in_valid_1 = 1'b1;
            alpha_i    = 6'(10 + i);
            a_i        = 3'(i + 1);
            d_i        = 3'(i + 1);
            tick();
        end
        in_valid_1 = 1'b0;
        n_cmp++;
        if (err_short !== 1'b0) begin
            n_err++;
            $display("FAIL short_early: got err_short=%b want 0", err_short);
        end
        tick();
        n_cmp++;
        if (err_short !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL short_pulse: got err_short=%b busy=%b want 1 0", err_short, busy);
        end
        n_cmp++;
        if (core_a !== 12'b000_000_010_001 || core_alpha !== 24'h0002CA) begin
            n_err++;
            $display("FAIL short_table: got a=%h alpha=%h want a=011 alpha=0002ca",
                     core_a, core_alpha);
        end
        tick();
        n_cmp++;
        if (err_short !== 1'b0) begin
            n_err++;
            $display("FAIL short_one_cycle: got err_short=%b want 0", err_short);
        end
    endtask

    task automatic test_overflow();
        drive_load();
        core_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid_2 = 1'b1;
            theta_vec  = tv(20 + k);
            tick();
            n_cmp++;
            if (err_ovf !== (k >= 4)) begin
                n_err++;
                $display("FAIL ovf_pulse%0d: got err_ovf=%b want %b", k, err_ovf, k >= 4);
            end
        end
        in_valid_2 = 1'b0;
        tick();
        n_cmp++;
        if (err_ovf !== 1'b0 || dut.pending_q !== 4'd4 || dut.state_q !== 2'd3) begin
            n_err++;
            $display("FAIL ovf_drain: got err_ovf=%b pending=%0d state=%0d want 0 4 3",
                     err_ovf, dut.pending_q, dut.state_q);
        end
        core_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (core_valid !== 1'b1 || core_theta !== tv(20 + k)) begin
                n_err++;
                $display("FAIL ovf_issue%0d: got valid=%b theta=%h want valid=1 theta=%h",
                         k, core_valid, core_theta, tv(20 + k));
            end
            tick();
        end
        n_cmp++;
        if (core_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_issue_count: got valid=%b want 0", core_valid);
        end
        core_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            res_valid = 1'b1;
            res_x = 9'(20 + k);
            res_y = 9'd1;
            res_z = 9'd2;
            tick();
            last_x = 9'(20 + k);
        end
        res_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_x !== 9'd23) begin
            n_err++;
            $display("FAIL ovf_last_result: got v=%b x=%0d want v=1 x=23", out_valid, out_x);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_idle: got busy=%b v=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_spurious();
        res_valid = 1'b1;
        res_x = 9'd55;
        tick();
        res_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_x !== (HOLD ? last_x : 9'd0)) begin
            n_err++;
            $display("FAIL spurious_idle: got v=%b x=%0d want v=0 x=%0d",
                     out_valid, out_x, HOLD ? last_x : 9'd0);
        end
        drive_load();
        core_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid_2 = 1'b1;
            theta_vec  = tv(40 + k);
            tick();
        end
        n_cmp++;
        if (dut.pending_q !== 4'd2) begin
            n_err++;
            $display("FAIL simul_pre: got pending=%0d want 2", dut.pending_q);
        end
        res_valid = 1'b1;
        res_x = 9'd77;
        res_y = 9'd78;
        res_z = 9'd79;
        theta_vec = tv(42);
        tick();
        last_x = 9'd77;
        res_valid  = 1'b0;
        in_valid_2 = 1'b0;
        n_cmp++;
        if (dut.pending_q !== 4'd2 || out_valid !== 1'b1 || out_x !== 9'd77) begin
            n_err++;
            $display("FAIL simul_pending: got pending=%0d v=%b x=%0d want 2 1 77",
                     dut.pending_q, out_valid, out_x);
        end
        tick();
        n_cmp++;
        if (dut.state_q !== 2'd3 || dut.pending_q !== 4'd2 || out_x !== (HOLD ? 9'd77 : 9'd0)) begin
            n_err++;
            $display("FAIL simul_drain: got state=%0d pending=%0d x=%0d want 3 2 %0d",
                     dut.state_q, dut.pending_q, out_x, HOLD ? 77 : 0);
        end
    endtask

    task automatic test_reset_mid_drain();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({core_valid, busy, out_valid, err_short, err_ovf} !== 5'b0
            || {core_theta, core_alpha, core_a, core_d, out_x, out_y, out_z} !== '0) begin
            n_err++;
            $display("FAIL rst_drain_outputs: got valid=%b busy=%b v=%b x=%0d alpha=%h want all 0",
                     core_valid, busy, out_valid, out_x, core_alpha);
        end
        n_cmp++;
        if (dut.pending_q !== 4'd0) begin
            n_err++;
            $display("FAIL rst_drain_pending: got %0d want 0", dut.pending_q);
        end
        res_valid = 1'b1;
        res_x = 9'd99;
        tick();
        res_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_x !== 9'd0) begin
            n_err++;
            $display("FAIL rst_drain_late_res: got v=%b x=%0d want v=0 x=0", out_valid, out_x);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_drain_quiet: got v=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid_1 = 1'b0;
        alpha_i    = '0;
        a_i        = '0;
        d_i        = '0;
        in_valid_2 = 1'b0;
        theta_vec  = '0;
        core_ready = 1'b0;
        res_valid  = 1'b0;
        res_x      = '0;
        res_y      = '0;
        res_z      = '0;
        test_reset();
        test_load();
        test_streaming();
        test_short_burst();
        test_overflow();
        test_spurious();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
